// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch / load-store memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BEAT_W         = 2;
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_e;

  // Big-endian lane select: beat 0 is the most significant byte.
  function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w,
                                           input logic [BEAT_W-1:0] k);
    logic [7:0] b;
    b = w[31:24];
    case (k)
      2'd0: b = w[31:24];
      2'd1: b = w[23:16];
      2'd2: b = w[15:8];
      2'd3: b = w[7:0];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [WORD_W-1:0] set_byte(input logic [WORD_W-1:0] w,
                                                 input logic [BEAT_W-1:0] k,
                                                 input logic [7:0]        b);
    logic [WORD_W-1:0] r;
    r = w;
    case (k)
      2'd0: r[31:24] = b;
      2'd1: r[23:16] = b;
      2'd2: r[15:8]  = b;
      2'd3: r[7:0]   = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that turns fetch and load/store word requests into
// four big-endian byte beats on a shared single-port byte-wide memory.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [31:0]       ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic [31:0]       ls_rdata,
  output logic              ls_done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  port_e               last_q, last_d;
  port_e               port_q, port_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   wa_q, wa_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [WORD_W-1:0]   if_rdata_q, if_rdata_d;
  logic [WORD_W-1:0]   ls_rdata_q, ls_rdata_d;
  logic                if_done_q, if_done_d;
  logic                ls_done_q, ls_done_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   mem_adr_q, mem_adr_d;
  logic                mem_we_q, mem_we_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  port_e               sel;
  logic [31:0]         sel_addr;

  // Byte offset and bits above the array width never reach the array.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr, ls_addr};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      last_q      <= PORT_LS;
      port_q      <= PORT_IF;
      we_q        <= 1'b0;
      wa_q        <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      busy_q      <= 1'b0;
      mem_adr_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      last_q      <= last_d;
      port_q      <= port_d;
      we_q        <= we_d;
      wa_q        <= wa_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      if_done_q   <= if_done_d;
      ls_done_q   <= ls_done_d;
      busy_q      <= busy_d;
      mem_adr_q   <= mem_adr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    last_d      = last_q;
    port_d      = port_q;
    we_d        = we_q;
    wa_d        = wa_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_done_d   = 1'b0;
    ls_done_d   = 1'b0;
    mem_adr_d   = mem_adr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    sel         = PORT_IF;
    sel_addr    = if_addr;

    case (state_q)
      ST_IDLE: begin
        if (if_req || ls_req) begin
          // On a tie the port that was not served last wins.
          if (if_req && ls_req) sel = (last_q == PORT_LS) ? PORT_IF : PORT_LS;
          else                  sel = if_req ? PORT_IF : PORT_LS;
          sel_addr    = (sel == PORT_LS) ? ls_addr : if_addr;
          port_d      = sel;
          we_d        = (sel == PORT_LS) && ls_we;
          wa_d        = ADDR_W'({sel_addr[31:2], 2'b00});
          wdata_d     = ls_wdata;
          beat_d      = '0;
          state_d     = ST_XFER;
          mem_adr_d   = wa_d;
          mem_we_d    = we_d;
          mem_wdata_d = word_byte(ls_wdata, 2'd0);
        end
      end
      ST_XFER: begin
        if (!we_q) begin
          if (port_q == PORT_LS) ls_rdata_d = set_byte(ls_rdata_q, beat_q, mem_rdata);
          else                   if_rdata_d = set_byte(if_rdata_q, beat_q, mem_rdata);
        end
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          state_d   = ST_DONE;
          mem_we_d  = 1'b0;
          last_d    = port_q;
          if_done_d = (port_q == PORT_IF);
          ls_done_d = (port_q == PORT_LS);
        end else begin
          mem_adr_d   = wa_q + ADDR_W'(beat_q) + ADDR_W'(1);
          mem_wdata_d = word_byte(wdata_q, beat_q + 2'd1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign if_done   = if_done_q;
  assign ls_done   = ls_done_q;
  assign busy      = busy_q;
  assign mem_adr   = mem_adr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a byte-array memory and a
// transaction-level reference model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [31:0] if_rdata, ls_rdata;
  logic        if_done, ls_done, busy;
  logic [15:0] mem_adr;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic        init_en, poke_en;
  logic [15:0] poke_a;
  logic [7:0]  poke_d;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  bit          last_ls;
  logic [31:0] exp_if, exp_ls;
  logic [31:0] if_a_l, ls_a_l, ls_wd_l;
  bit          ls_we_l;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata), .ls_done(ls_done), .busy(busy),
    .mem_adr(mem_adr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_adr];

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'(i * 7 + 3);
    end else if (poke_en) begin
      mem[poke_a] <= poke_d;
    end else if (mem_we) begin
      mem[mem_adr] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_a = a; poke_d = d; poke_en = 1'b1;
    ref_mem[a] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic idle_cyc();
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_we", 32'(mem_we), 32'd0);
    chk("idle_done", 32'({if_done, ls_done}), 32'd0);
  endtask

  task automatic start(input bit en_if, input bit en_ls, input bit we,
                       input logic [31:0] ia, input logic [31:0] la, input logic [31:0] wd);
    if_addr = ia; ls_addr = la; ls_we = we; ls_wdata = wd;
    if_a_l = ia; ls_a_l = la; ls_we_l = we; ls_wd_l = wd;
    if_req = en_if; ls_req = en_ls;
  endtask

  // One granted transaction: grant edge just passed, beats at +1..+4, done at +5.
  task automatic serve(input bit p, input bit keep);
    logic [31:0] a;
    logic [31:0] wa;
    logic [31:0] word;
    bit          we;
    a  = p ? ls_a_l : if_a_l;
    we = p & ls_we_l;
    wa = {a[31:2], 2'b00};
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        chk("beat_busy", 32'(busy), 32'd1);
        chk("beat_adr", 32'(mem_adr), 32'(16'(wa + 32'(c - 1))));
        chk("beat_we", 32'(mem_we), 32'(we));
        if (we) chk("beat_wdata", 32'(mem_wdata), 32'(8'(ls_wd_l >> (8 * (4 - c)))));
        chk("early_done", 32'({if_done, ls_done}), 32'd0);
        if (c == 2 && !keep) begin
          if (p) begin
            ls_addr = $urandom; ls_wdata = $urandom; ls_we = 1'($urandom % 2);
          end else begin
            if_addr = $urandom;
          end
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (we) ref_mem[16'(wa + 32'(k))] = 8'(ls_wd_l >> (8 * (3 - k)));
          word = {word[23:0], ref_mem[16'(wa + 32'(k))]};
        end
        if (!we) begin
          if (p) exp_ls = word;
          else   exp_if = word;
        end
        chk(p ? "ls_done" : "if_done", 32'({if_done, ls_done}), p ? 32'd1 : 32'd2);
        chk("done_busy", 32'(busy), 32'd1);
        chk("if_rdata", if_rdata, exp_if);
        chk("ls_rdata", ls_rdata, exp_ls);
        last_ls = p;
        if (!keep) begin
          if (p) ls_req = 1'b0;
          else   if_req = 1'b0;
        end
      end
    end
  endtask

  task automatic run_pair(input bit en_if, input bit en_ls, input bit we,
                          input logic [31:0] ia, input logic [31:0] la, input logic [31:0] wd);
    bit first;
    start(en_if, en_ls, we, ia, la, wd);
    first = (en_if && en_ls) ? !last_ls : en_ls;
    serve(first, 1'b0);
    idle_cyc();
    if (en_if && en_ls) begin
      serve(!first, 1'b0);
      idle_cyc();
    end
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [31:0] a, t;
    int bad;
    rst = 1'b1; init_en = 1'b0; poke_en = 1'b0; poke_a = '0; poke_d = '0;
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0;
    last_ls = 1'b1; exp_if = '0; exp_ls = '0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i * 7 + 3);

    @(negedge clk); init_en = 1'b1;
    @(negedge clk); init_en = 1'b0;
    poke(16'h0000, 8'h13); poke(16'h0001, 8'h05); poke(16'h0002, 8'h00); poke(16'h0003, 8'h00);
    poke(16'hFFFC, 8'hA1); poke(16'hFFFD, 8'hB2); poke(16'hFFFE, 8'hC3); poke(16'hFFFF, 8'hD4);

    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_adr", 32'(mem_adr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_done", 32'({if_done, ls_done}), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);

    // tie straight out of reset: fetch first, then load/store
    rst = 1'b0;
    run_pair(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000FFFC, 32'h0);
    chk("tie1_if", if_rdata, 32'h13050000);
    chk("tie1_ls", ls_rdata, 32'hA1B2C3D4);
    // repeat tie: last was ls, so fetch wins again
    run_pair(1'b1, 1'b1, 1'b0, 32'h4, 32'h8, 32'h0);

    tbl[0] = '{1'b0, 1'b0, 32'h00000000, 32'h0,        32'h13050000};
    tbl[1] = '{1'b1, 1'b1, 32'h00000010, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b0, 32'h00000012, 32'h0,        32'hDEADBEEF};
    tbl[3] = '{1'b1, 1'b0, 32'h0000FFFC, 32'h0,        32'hA1B2C3D4};
    tbl[4] = '{1'b1, 1'b0, 32'h00010000, 32'h0,        32'h13050000};
    tbl[5] = '{1'b0, 1'b0, 32'h00000013, 32'h0,        32'hDEADBEEF};
    tbl[6] = '{1'b0, 1'b0, 32'hABCDFFFE, 32'h0,        32'hA1B2C3D4};
    for (int i = 0; i < 7; i++) begin
      run_pair(!tbl[i].port, tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].addr, tbl[i].wdata);
      if (tbl[i].we) begin
        a = {tbl[i].addr[31:2], 2'b00};
        t = {mem[16'(a)], mem[16'(a + 1)], mem[16'(a + 2)], mem[16'(a + 3)]};
        chk("tbl_store", t, tbl[i].exp_rdata);
      end else begin
        chk("tbl_load", tbl[i].port ? ls_rdata : if_rdata, tbl[i].exp_rdata);
      end
    end

    // reset after beat 1 of a store
    start(1'b0, 1'b1, 1'b1, 32'h0, 32'h20, 32'h11223344);
    @(negedge clk);
    chk("rs_adr0", 32'(mem_adr), 32'h20);
    @(negedge clk);
    chk("rs_wdata1", 32'(mem_wdata), 32'h22);
    rst = 1'b1; ls_req = 1'b0;
    @(negedge clk);
    chk("rs_we", 32'(mem_we), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_done", 32'({if_done, ls_done}), 32'd0);
    chk("rs_ls_rdata", ls_rdata, 32'd0);
    chk("rs_if_rdata", if_rdata, 32'd0);
    ref_mem[16'h20] = 8'h11; ref_mem[16'h21] = 8'h22;
    exp_if = '0; exp_ls = '0; last_ls = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) idle_cyc();
    chk("rs_b20", 32'(mem[16'h20]), 32'h11);
    chk("rs_b21", 32'(mem[16'h21]), 32'h22);
    chk("rs_b22", 32'(mem[16'h22]), 32'(8'(16'h22 * 7 + 3)));
    chk("rs_b23", 32'(mem[16'h23]), 32'(8'(16'h23 * 7 + 3)));

    // held ls_req: a second transaction follows without a gap request
    start(1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 32'h0);
    serve(1'b1, 1'b1);
    idle_cyc();
    serve(1'b1, 1'b0);
    idle_cyc();
    chk("held_rdata", ls_rdata, 32'hDEADBEEF);

    // randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      bit ei, el, w;
      logic [31:0] ia, la;
      ei = 1'($urandom % 2);
      el = 1'($urandom % 2);
      if (!ei && !el) ei = 1'b1;
      w = 1'($urandom % 2);
      case ($urandom % 3)
        0: begin ia = ($urandom & 32'hFFFF0000) | 32'h0000FFFD; la = $urandom % 64; end
        1: begin ia = $urandom % 64; la = ($urandom & 32'hFFFF0000) | 32'h0000FFFE; end
        default: begin ia = $urandom; la = $urandom; end
      endcase
      run_pair(ei, el, w, ia, la, $urandom);
    end

    bad = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
